ex_stage: RTL

- Execute stage that consumes the decode/execute pipeline register outputs (DEC_*), one instruction per cycle.
- Resolves operand forwarding, ALU, compare and branch/JAL outcome, and flags mispredicts for the fetch/decode stages.
- Registers results into the EX/MEM pipeline register feeding the memory stage.
- Keeps branch and mispredict performance counters.

---
 rtl/ex_pkg.sv | 39 +++
 rtl/ex_alu.sv | 52 +++++
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared opcode, function and operand-select encodings for the execute stage.
package ex_pkg;

   // Opcodes
   localparam logic [3:0] OP_ALUR  = 4'hC;
   localparam logic [3:0] OP_ALUI  = 4'h4;
   localparam logic [3:0] OP_CMPR  = 4'hD;
   localparam logic [3:0] OP_CMPI  = 4'h5;
   localparam logic [3:0] OP_BCOND = 4'h6;
   localparam logic [3:0] OP_SW    = 4'h7;
   localparam logic [3:0] OP_LW    = 4'h9;
   localparam logic [3:0] OP_JAL   = 4'hB;

   // ALU function codes
   localparam logic [3:0] FN_ADD  = 4'h0;
   localparam logic [3:0] FN_SUB  = 4'h1;
   localparam logic [3:0] FN_AND  = 4'h4;
   localparam logic [3:0] FN_OR   = 4'h5;
   localparam logic [3:0] FN_XOR  = 4'h6;
   localparam logic [3:0] FN_NAND = 4'hC;
   localparam logic [3:0] FN_NOR  = 4'hD;
   localparam logic [3:0] FN_XNOR = 4'hE;

   // Compare function codes (signed)
   localparam logic [3:0] CMP_F   = 4'h0;
   localparam logic [3:0] CMP_EQ  = 4'h1;
   localparam logic [3:0] CMP_LT  = 4'h2;
   localparam logic [3:0] CMP_LTE = 4'h3;
   localparam logic [3:0] CMP_T   = 4'h8;
   localparam logic [3:0] CMP_NE  = 4'h9;
   localparam logic [3:0] CMP_GTE = 4'hA;
   localparam logic [3:0] CMP_GT  = 4'hB;

   // Second ALU operand select; encoding 3 falls back to rs2 data
   localparam logic [1:0] SEL_RS2     = 2'd0;
   localparam logic [1:0] SEL_IMM     = 2'd1;
   localparam logic [1:0] SEL_IMM_SH2 = 2'd2;

endpackage

// File: rtl/ex_alu.sv
// Combinational logic unit and signed comparator of the execute stage.
module ex_alu
   import ex_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic [3:0]       func,
   input  logic [DBITS-1:0] op_a,
   input  logic [DBITS-1:0] op_b,
   output logic [DBITS-1:0] alu_result,
   output logic             cmp_result
);

   logic eq_s;
   logic lt_s;

   assign eq_s = (op_a == op_b);
   assign lt_s = ($signed(op_a) < $signed(op_b));

   // Arithmetic/logic result, wrapping modulo 2^DBITS; unknown functions give 0
   always_comb begin
      alu_result = {DBITS{1'b0}};
      case (func)
         FN_ADD:  alu_result = op_a + op_b;
         FN_SUB:  alu_result = op_a - op_b;
         FN_AND:  alu_result = op_a & op_b;
         FN_OR:   alu_result = op_a | op_b;
         FN_XOR:  alu_result = op_a ^ op_b;
         FN_NAND: alu_result = ~(op_a & op_b);
         FN_NOR:  alu_result = ~(op_a | op_b);
         FN_XNOR: alu_result = ~(op_a ^ op_b);
         default: alu_result = {DBITS{1'b0}};
      endcase
   end

   // Signed comparison outcome; unknown conditions evaluate false
   always_comb begin
      cmp_result = 1'b0;
      case (func)
         CMP_F:   cmp_result = 1'b0;
         CMP_EQ:  cmp_result = eq_s;
         CMP_LT:  cmp_result = lt_s;
         CMP_LTE: cmp_result = lt_s | eq_s;
         CMP_T:   cmp_result = 1'b1;
         CMP_NE:  cmp_result = ~eq_s;
         CMP_GTE: cmp_result = ~lt_s;
         CMP_GT:  cmp_result = ~lt_s & ~eq_s;
         default: cmp_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/compare, branch and JAL resolution,
// mispredict redirect, EX/MEM pipeline register and branch statistics.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DBITS               = 32,
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int CNT_BITS            = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           EX_wrt_en,
   input  logic                           EX_flush,
   input  logic [DBITS-1:0]               DEC_pc,
   input  logic [DBITS-1:0]               DEC_brBaseOffset,
   input  logic [DBITS-1:0]               DEC_immval,
   input  logic [DBITS-1:0]               DEC_regData1,
   input  logic [DBITS-1:0]               DEC_regData2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs1,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rs2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] DEC_rd,
   input  logic [3:0]                     EX_op,
   input  logic [3:0]                     EX_func,
   input  logic                           DEC_prediction,
   input  logic                           DEC_wrReg,
   input  logic                           DEC_wrMem,
   input  logic                           DEC_ME_Mux_sel,
   input  logic [1:0]                     DEC_alu2MuxSel,
   input  logic                           MEM_wrReg,
   input  logic                           WB_wrReg,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] MEM_rd,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] WB_rd,
   input  logic [DBITS-1:0]               MEM_result,
   input  logic [DBITS-1:0]               WB_data,
   output logic                           ex_mispredict,
   output logic [DBITS-1:0]               ex_redirect_pc,
   output logic [DBITS-1:0]               EXM_result,
   output logic [DBITS-1:0]               EXM_storeData,
   output logic [REG_INDEX_BIT_WIDTH-1:0] EXM_rd,
   output logic                           EXM_wrReg,
   output logic                           EXM_wrMem,
   output logic                           EXM_memToReg,
   output logic [CNT_BITS-1:0]            br_count,
   output logic [CNT_BITS-1:0]            mispred_count
);

   localparam logic [REG_INDEX_BIT_WIDTH-1:0] REG_ZERO = {REG_INDEX_BIT_WIDTH{1'b0}};
   localparam logic [CNT_BITS-1:0]            CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0]            CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

   logic [DBITS-1:0] fwd_a_s;
   logic [DBITS-1:0] fwd_b_s;
   logic [DBITS-1:0] opnd_b_s;
   logic [DBITS-1:0] alu_b_s;
   logic [DBITS-1:0] alu_result_s;
   logic             cmp_result_s;
   logic [DBITS-1:0] mem_addr_s;
   logic [DBITS-1:0] jal_target_s;
   logic [DBITS-1:0] result_s;
   logic [DBITS-1:0] target_s;
   logic             taken_s;
   logic             is_br_s;
   logic             is_jal_s;
   logic             mispredict_s;
   logic             advance_s;
   logic             redirect_done_r;

   // Source A bypass: MEM stage wins over WB; register 0 is never bypassed
   always_comb begin
      fwd_a_s = DEC_regData1;
      if (MEM_wrReg && (MEM_rd == DEC_rs1) && (DEC_rs1 != REG_ZERO)) begin
         fwd_a_s = MEM_result;
      end else if (WB_wrReg && (WB_rd == DEC_rs1) && (DEC_rs1 != REG_ZERO)) begin
         fwd_a_s = WB_data;
      end else begin
         fwd_a_s = DEC_regData1;
      end
   end

   // Source B bypass, same priority as source A
   always_comb begin
      fwd_b_s = DEC_regData2;
      if (MEM_wrReg && (MEM_rd == DEC_rs2) && (DEC_rs2 != REG_ZERO)) begin
         fwd_b_s = MEM_result;
      end else if (WB_wrReg && (WB_rd == DEC_rs2) && (DEC_rs2 != REG_ZERO)) begin
         fwd_b_s = WB_data;
      end else begin
         fwd_b_s = DEC_regData2;
      end
   end

   // Second ALU operand; conditional branches always compare the two registers
   always_comb begin
      opnd_b_s = fwd_b_s;
      case (DEC_alu2MuxSel)
         SEL_IMM:     opnd_b_s = DEC_immval;
         SEL_IMM_SH2: opnd_b_s = DEC_immval << 2'd2;
         default:     opnd_b_s = fwd_b_s;
      endcase
      if (EX_op == OP_BCOND) begin
         alu_b_s = fwd_b_s;
      end else begin
         alu_b_s = opnd_b_s;
      end
   end

   assign mem_addr_s   = fwd_a_s + DEC_immval;
   assign jal_target_s = fwd_a_s + (DEC_immval << 2'd2);

   ex_alu #(.DBITS(DBITS)) u_alu (
      .func       (EX_func),
      .op_a       (fwd_a_s),
      .op_b       (alu_b_s),
      .alu_result (alu_result_s),
      .cmp_result (cmp_result_s)
   );

   // Per-opcode result and control-flow outcome; unknown opcodes act as NOP
   always_comb begin
      result_s = {DBITS{1'b0}};
      target_s = DEC_brBaseOffset;
      taken_s  = 1'b0;
      is_br_s  = 1'b0;
      is_jal_s = 1'b0;
      case (EX_op)
         OP_ALUR, OP_ALUI: result_s = alu_result_s;
         OP_CMPR, OP_CMPI: result_s = {{(DBITS-1){1'b0}}, cmp_result_s};
         OP_BCOND: begin
            is_br_s = 1'b1;
            taken_s = cmp_result_s;
         end
         OP_LW, OP_SW: result_s = mem_addr_s;
         OP_JAL: begin
            is_jal_s = 1'b1;
            taken_s  = 1'b1;
            target_s = jal_target_s;
            result_s = DEC_pc;
         end
         default: result_s = {DBITS{1'b0}};
      endcase
   end

   assign mispredict_s   = is_jal_s | (is_br_s & (taken_s != DEC_prediction));
   assign ex_mispredict  = mispredict_s & ~redirect_done_r;
   assign ex_redirect_pc = taken_s ? target_s : DEC_pc;
   assign advance_s      = EX_wrt_en & ~EX_flush;

   // Remember a redirect already issued for a stalled instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_done_r <= 1'b0;
      end else if (EX_wrt_en) begin
         redirect_done_r <= 1'b0;
      end else if (ex_mispredict) begin
         redirect_done_r <= 1'b1;
      end
   end

   // EX/MEM pipeline register: flush beats advance, otherwise hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         EXM_result    <= {DBITS{1'b0}};
         EXM_storeData <= {DBITS{1'b0}};
         EXM_rd        <= REG_ZERO;
         EXM_wrReg     <= 1'b0;
         EXM_wrMem     <= 1'b0;
         EXM_memToReg  <= 1'b0;
      end else if (EX_flush) begin
         EXM_result    <= {DBITS{1'b0}};
         EXM_storeData <= {DBITS{1'b0}};
         EXM_rd        <= REG_ZERO;
         EXM_wrReg     <= 1'b0;
         EXM_wrMem     <= 1'b0;
         EXM_memToReg  <= 1'b0;
      end else if (EX_wrt_en) begin
         EXM_result    <= result_s;
         EXM_storeData <= fwd_b_s;
         EXM_rd        <= DEC_rd;
         EXM_wrReg     <= DEC_wrReg;
         EXM_wrMem     <= DEC_wrMem;
         EXM_memToReg  <= DEC_ME_Mux_sel;
      end
   end

   // Saturating branch and mispredict counters, counted once per retired branch/JAL
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_count      <= {CNT_BITS{1'b0}};
         mispred_count <= {CNT_BITS{1'b0}};
      end else if (advance_s && (is_br_s || is_jal_s)) begin
         if (br_count != CNT_MAX) begin
            br_count <= br_count + CNT_ONE;
         end
         if (mispredict_s && (mispred_count != CNT_MAX)) begin
            mispred_count <= mispred_count + CNT_ONE;
         end
      end
   end

endmodule
